// File: rtl/ext_mem_bridge.sv
// CPU-to-external-RAM bridge with an optionally multiplexed address bus.
// Outputs are registered and decoded from the next state so that the pins are glitch-free.
module ext_mem_bridge #(
    parameter int ADDR_W      = 8,
    parameter int PIN_ADDR_W  = 5,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_ready,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_busy,
    output logic [PIN_ADDR_W-1:0] pin_addr,
    output logic                  pin_ale,
    output logic                  pin_we,
    output logic                  pin_oe,
    output logic [DATA_W-1:0]     pin_data_out,
    output logic                  pin_data_oe,
    input  logic [DATA_W-1:0]     pin_data_in
);

    localparam bit SPLIT = (ADDR_W > PIN_ADDR_W);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR_HI = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_STROBE  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [PIN_ADDR_W-1:0] pin_addr_q, pin_addr_d;
    logic                  pin_ale_q, pin_ale_d;
    logic                  pin_we_q, pin_we_d;
    logic                  pin_oe_q, pin_oe_d;
    logic [DATA_W-1:0]     pin_data_out_q, pin_data_out_d;
    logic                  pin_data_oe_q, pin_data_oe_d;

    // Zero-extended to two pin widths so the high half is always a legal slice.
    logic [2*PIN_ADDR_W-1:0] addr_ext;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = SPLIT ? S_ADDR_HI : S_SETUP;
                end
            end
            S_ADDR_HI: state_d = S_SETUP;
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = pin_data_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign addr_ext = (2*PIN_ADDR_W)'(addr_d);

    always_comb begin
        pin_addr_d     = pin_addr_q;
        pin_data_out_d = pin_data_out_q;
        pin_ale_d      = 1'b0;
        pin_we_d       = 1'b0;
        pin_oe_d       = 1'b0;
        pin_data_oe_d  = 1'b0;

        case (state_d)
            S_ADDR_HI: begin
                pin_addr_d = addr_ext[2*PIN_ADDR_W-1:PIN_ADDR_W];
                pin_ale_d  = 1'b1;
            end
            S_SETUP, S_STROBE: begin
                pin_addr_d = addr_ext[PIN_ADDR_W-1:0];
                if (we_d) begin
                    pin_data_oe_d  = 1'b1;
                    pin_data_out_d = wdata_d;
                    pin_we_d       = (state_d == S_STROBE);
                end else begin
                    pin_oe_d = 1'b1;
                end
            end
            S_DONE: begin
                // Write data and address stay driven one more cycle for hold time.
                pin_data_oe_d = we_d;
            end
            default: ;
        endcase

        ready_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            rdata_q        <= '0;
            ready_q        <= 1'b0;
            busy_q         <= 1'b0;
            pin_addr_q     <= '0;
            pin_ale_q      <= 1'b0;
            pin_we_q       <= 1'b0;
            pin_oe_q       <= 1'b0;
            pin_data_out_q <= '0;
            pin_data_oe_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            rdata_q        <= rdata_d;
            ready_q        <= ready_d;
            busy_q         <= busy_d;
            pin_addr_q     <= pin_addr_d;
            pin_ale_q      <= pin_ale_d;
            pin_we_q       <= pin_we_d;
            pin_oe_q       <= pin_oe_d;
            pin_data_out_q <= pin_data_out_d;
            pin_data_oe_q  <= pin_data_oe_d;
        end
    end

    assign cpu_ready    = ready_q;
    assign cpu_rdata    = rdata_q;
    assign cpu_busy     = busy_q;
    assign pin_addr     = pin_addr_q;
    assign pin_ale      = pin_ale_q;
    assign pin_we       = pin_we_q;
    assign pin_oe       = pin_oe_q;
    assign pin_data_out = pin_data_out_q;
    assign pin_data_oe  = pin_data_oe_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed bench for ext_mem_bridge: split-address instance plus two non-split instances.
// Cycle k is counted from the accept cycle (k=0); outputs are sampled on the falling edge.
module tb_ext_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_a, req_b, req_c;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] pin_data_in;

    logic       a_ready, a_busy, a_ale, a_pwe, a_poe, a_pdoe;
    logic [7:0] a_rdata, a_pdout;
    logic [4:0] a_paddr;
    logic       b_ready, b_busy, b_ale, b_pwe, b_poe, b_pdoe;
    logic [7:0] b_rdata, b_pdout;
    logic [4:0] b_paddr;
    logic       c_ready, c_busy, c_ale, c_pwe, c_poe, c_pdoe;
    logic [7:0] c_rdata, c_pdout;
    logic [4:0] c_paddr;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic a_rdy_prev = 1'b0, b_rdy_prev = 1'b0, c_rdy_prev = 1'b0;

    ext_mem_bridge #(.ADDR_W(8), .PIN_ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .reset(reset), .cpu_req(req_a), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(a_ready), .cpu_rdata(a_rdata), .cpu_busy(a_busy),
        .pin_addr(a_paddr), .pin_ale(a_ale), .pin_we(a_pwe), .pin_oe(a_poe),
        .pin_data_out(a_pdout), .pin_data_oe(a_pdoe), .pin_data_in(pin_data_in)
    );

    ext_mem_bridge #(.ADDR_W(5), .PIN_ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .cpu_req(req_b), .cpu_we(cpu_we), .cpu_addr(cpu_addr[4:0]),
        .cpu_wdata(cpu_wdata), .cpu_ready(b_ready), .cpu_rdata(b_rdata), .cpu_busy(b_busy),
        .pin_addr(b_paddr), .pin_ale(b_ale), .pin_we(b_pwe), .pin_oe(b_poe),
        .pin_data_out(b_pdout), .pin_data_oe(b_pdoe), .pin_data_in(pin_data_in)
    );

    ext_mem_bridge #(.ADDR_W(5), .PIN_ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(3)) u_c (
        .clk(clk), .reset(reset), .cpu_req(req_c), .cpu_we(cpu_we), .cpu_addr(cpu_addr[4:0]),
        .cpu_wdata(cpu_wdata), .cpu_ready(c_ready), .cpu_rdata(c_rdata), .cpu_busy(c_busy),
        .pin_addr(c_paddr), .pin_ale(c_ale), .pin_we(c_pwe), .pin_oe(c_poe),
        .pin_data_out(c_pdout), .pin_data_oe(c_pdoe), .pin_data_in(pin_data_in)
    );

    // Bus-safety invariants and single-cycle ready, checked every cycle after reset.
    always @(negedge clk) begin
        if (mon_en) begin
            checks = checks + 1;
            if ((a_poe && a_pdoe) || (a_pwe && !a_pdoe) || (a_ready && a_rdy_prev)) begin
                errors = errors + 1;
                $display("FAIL inv_a t=%0t got oe=%b doe=%b we=%b rdy=%b prev=%b exp legal", $time,
                         a_poe, a_pdoe, a_pwe, a_ready, a_rdy_prev);
            end
            checks = checks + 1;
            if ((b_poe && b_pdoe) || (b_pwe && !b_pdoe) || (b_ready && b_rdy_prev) || b_ale) begin
                errors = errors + 1;
                $display("FAIL inv_b t=%0t got oe=%b doe=%b we=%b rdy=%b ale=%b exp legal", $time,
                         b_poe, b_pdoe, b_pwe, b_ready, b_ale);
            end
            checks = checks + 1;
            if ((c_poe && c_pdoe) || (c_pwe && !c_pdoe) || (c_ready && c_rdy_prev) || c_ale) begin
                errors = errors + 1;
                $display("FAIL inv_c t=%0t got oe=%b doe=%b we=%b rdy=%b ale=%b exp legal", $time,
                         c_poe, c_pdoe, c_pwe, c_ready, c_ale);
            end
        end
        a_rdy_prev = a_ready;
        b_rdy_prev = b_ready;
        c_rdy_prev = c_ready;
    end

    task automatic test_reset();
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00; pin_data_in = 8'h00;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if ({a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy} !== 6'b0) begin
            errors = errors + 1;
            $display("FAIL reset_ctl_a got %b exp 000000", {a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy});
        end
        checks = checks + 1;
        if ({a_paddr, a_pdout, a_rdata} !== 21'h0) begin
            errors = errors + 1;
            $display("FAIL reset_data_a got addr=%h dout=%h rdata=%h exp 0", a_paddr, a_pdout, a_rdata);
        end
        checks = checks + 1;
        if ({b_busy, b_ready, b_poe, b_rdata, c_busy, c_ready, c_poe, c_rdata} !== 22'h0) begin
            errors = errors + 1;
            $display("FAIL reset_bc got b=%b%b%b %h c=%b%b%b %h exp 0", b_busy, b_ready, b_poe, b_rdata,
                     c_busy, c_ready, c_poe, c_rdata);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (a_busy !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_idle got busy=%b exp 0", a_busy);
        end
    endtask

    task automatic test_read_split();
        logic [5:0] exp_ctl;
        logic [4:0] exp_addr;
        logic [7:0] exp_rdata;
        cpu_we = 1'b0; cpu_addr = 8'hBA; pin_data_in = 8'h5C; req_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            // {ale, oe, we, data_oe, ready, busy}
            case (k)
                1:       exp_ctl = 6'b100001;
                2, 3, 4: exp_ctl = 6'b010001;
                5:       exp_ctl = 6'b000011;
                default: exp_ctl = 6'b000000;
            endcase
            exp_addr  = (k == 1) ? 5'h05 : 5'h1A;
            exp_rdata = (k >= 5) ? 8'h5C : 8'h00;
            checks = checks + 1;
            if ({a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy} !== exp_ctl) begin
                errors = errors + 1;
                $display("FAIL read_ctl k=%0d got %b exp %b", k, {a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy}, exp_ctl);
            end
            checks = checks + 1;
            if (a_paddr !== exp_addr) begin
                errors = errors + 1;
                $display("FAIL read_addr k=%0d got %h exp %h", k, a_paddr, exp_addr);
            end
            checks = checks + 1;
            if (a_rdata !== exp_rdata) begin
                errors = errors + 1;
                $display("FAIL read_rdata k=%0d got %h exp %h", k, a_rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_write_split();
        logic [5:0] exp_ctl;
        logic [7:0] exp_dout;
        cpu_we = 1'b1; cpu_addr = 8'hE7; cpu_wdata = 8'h3F; pin_data_in = 8'h99; req_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            case (k)
                1:       exp_ctl = 6'b100001;
                2:       exp_ctl = 6'b000101;
                3, 4:    exp_ctl = 6'b001101;
                5:       exp_ctl = 6'b000111;
                default: exp_ctl = 6'b000000;
            endcase
            exp_dout = (k >= 2) ? 8'h3F : 8'h00;
            checks = checks + 1;
            if ({a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy} !== exp_ctl) begin
                errors = errors + 1;
                $display("FAIL write_ctl k=%0d got %b exp %b", k, {a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy}, exp_ctl);
            end
            checks = checks + 1;
            if ({a_paddr, a_pdout} !== {5'h07, exp_dout}) begin
                errors = errors + 1;
                $display("FAIL write_pins k=%0d got addr=%h dout=%h exp addr=07 dout=%h", k, a_paddr, a_pdout, exp_dout);
            end
            checks = checks + 1;
            if (a_rdata !== 8'h5C) begin
                errors = errors + 1;
                $display("FAIL write_rdata k=%0d got %h exp 5c", k, a_rdata);
            end
        end
    endtask

    task automatic test_nonsplit();
        logic [3:0] exp_b, exp_c;
        cpu_we = 1'b0; cpu_addr = 8'h11; pin_data_in = 8'hA7; req_b = 1'b1; req_c = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req_b = 1'b0; req_c = 1'b0;
            // {ale, oe, ready, busy}
            exp_b = (k <= 2) ? 4'b0101 : (k == 3) ? 4'b0011 : 4'b0000;
            exp_c = (k <= 5) ? 4'b0101 : (k == 6) ? 4'b0011 : 4'b0000;
            checks = checks + 1;
            if ({b_ale, b_poe, b_ready, b_busy} !== exp_b || b_paddr !== 5'h11
                || b_rdata !== ((k >= 3) ? 8'hA7 : 8'h00)) begin
                errors = errors + 1;
                $display("FAIL nosplit_w0 k=%0d got ctl=%b addr=%h rdata=%h exp ctl=%b addr=11", k,
                         {b_ale, b_poe, b_ready, b_busy}, b_paddr, b_rdata, exp_b);
            end
            checks = checks + 1;
            if ({c_ale, c_poe, c_ready, c_busy} !== exp_c || c_paddr !== 5'h11
                || c_rdata !== ((k >= 6) ? 8'hA7 : 8'h00)) begin
                errors = errors + 1;
                $display("FAIL nosplit_w3 k=%0d got ctl=%b addr=%h rdata=%h exp ctl=%b addr=11", k,
                         {c_ale, c_poe, c_ready, c_busy}, c_paddr, c_rdata, exp_c);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        cpu_we = 1'b1; cpu_addr = 8'h45; cpu_wdata = 8'hC3; req_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            if (k == 4) begin
                checks = checks + 1;
                if ({a_pwe, a_pdoe, a_busy} !== 3'b111) begin
                    errors = errors + 1;
                    $display("FAIL rst_pre k=4 got we/doe/busy=%b exp 111", {a_pwe, a_pdoe, a_busy});
                end
                reset = 1'b1;
            end else if (k == 5) begin
                checks = checks + 1;
                if ({a_pwe, a_pdoe, a_busy, a_ready, a_paddr, a_pdout, a_rdata} !== 25'h0) begin
                    errors = errors + 1;
                    $display("FAIL rst_post got we=%b doe=%b busy=%b rdy=%b addr=%h dout=%h rdata=%h exp 0",
                             a_pwe, a_pdoe, a_busy, a_ready, a_paddr, a_pdout, a_rdata);
                end
                reset = 1'b0;
            end else if (k > 5) begin
                checks = checks + 1;
                if ({a_ready, a_busy} !== 2'b00) begin
                    errors = errors + 1;
                    $display("FAIL rst_discard k=%0d got ready/busy=%b exp 00", k, {a_ready, a_busy});
                end
            end
        end
    endtask

    task automatic test_req_during_reset();
        cpu_we = 1'b0; cpu_addr = 8'hBA; reset = 1'b1; req_a = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                reset = 1'b0;
                req_a = 1'b0;
            end
            checks = checks + 1;
            if ({a_busy, a_ale, a_ready} !== 3'b000) begin
                errors = errors + 1;
                $display("FAIL req_in_reset k=%0d got busy/ale/rdy=%b exp 000", k, {a_busy, a_ale, a_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ctl;
        logic [4:0] exp_addr;
        logic [7:0] exp_rdata;
        cpu_we = 1'b0; cpu_addr = 8'h20; pin_data_in = 8'h11; req_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) cpu_addr = 8'h40;
            if (k == 6) pin_data_in = 8'h22;
            if (k == 7) req_a = 1'b0;
            case (k)
                1, 7:            exp_ctl = 6'b100001;
                2, 3, 4, 8, 9, 10: exp_ctl = 6'b010001;
                5, 11:           exp_ctl = 6'b000011;
                default:         exp_ctl = 6'b000000;
            endcase
            exp_addr  = (k == 1) ? 5'h01 : (k == 7) ? 5'h02 : 5'h00;
            exp_rdata = (k >= 11) ? 8'h22 : (k >= 5) ? 8'h11 : 8'h00;
            checks = checks + 1;
            if ({a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy} !== exp_ctl) begin
                errors = errors + 1;
                $display("FAIL b2b_ctl k=%0d got %b exp %b", k, {a_ale, a_poe, a_pwe, a_pdoe, a_ready, a_busy}, exp_ctl);
            end
            checks = checks + 1;
            if ({a_paddr, a_rdata} !== {exp_addr, exp_rdata}) begin
                errors = errors + 1;
                $display("FAIL b2b_data k=%0d got addr=%h rdata=%h exp addr=%h rdata=%h", k, a_paddr, a_rdata,
                         exp_addr, exp_rdata);
            end
        end
    endtask

    task automatic test_req_ignored();
        cpu_we = 1'b0; cpu_addr = 8'h20; req_a = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            req_a = (k == 2 || k == 3);
            checks = checks + 1;
            if ({a_ready, a_busy} !== {(k == 5), (k <= 5)}) begin
                errors = errors + 1;
                $display("FAIL req_ignored k=%0d got ready/busy=%b exp %b", k, {a_ready, a_busy}, {(k == 5), (k <= 5)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_split();
        test_write_split();
        test_nonsplit();
        test_reset_mid_write();
        test_req_during_reset();
        test_back_to_back();
        test_req_ignored();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ext_mem_bridge.md
EXT_MEM_BRIDGE -- requirements
Module: ext_mem_bridge

Interface
Parameters:
REQ-001 ADDR_W, 8, CPU address width; SHALL satisfy PIN_ADDR_W <= ADDR_W <= 2*PIN_ADDR_W.
REQ-002 PIN_ADDR_W, 5, external address pin count.
REQ-003 DATA_W, 8, data bus width.
REQ-004 WAIT_CYCLES, 1, extra strobe cycles, range 0..15.
Ports:
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpu_req  in  1  transaction request; sampled only in IDLE.
REQ-008 cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
REQ-009 cpu_addr  in  ADDR_W  target address; sampled with cpu_req.
REQ-010 cpu_wdata  in  DATA_W  write data; sampled with cpu_req.
REQ-011 cpu_ready  out  1  one-cycle completion pulse.
REQ-012 cpu_rdata  out  DATA_W  registered read data; holds until next read completes.
REQ-013 cpu_busy  out  1  high whenever state != IDLE.
REQ-014 pin_addr  out  PIN_ADDR_W  multiplexed external address.
REQ-015 pin_ale  out  1  address-latch enable for high address part.
REQ-016 pin_we  out  1  external RAM write enable.
REQ-017 pin_oe  out  1  external RAM output enable.
REQ-018 pin_data_out  out  DATA_W  write data to pins.
REQ-019 pin_data_oe  out  1  bus drive enable (1=drive pins).
REQ-020 pin_data_in  in  DATA_W  read data from pins.

Function
REQ-021 SPLIT mode SHALL be active iff ADDR_W > PIN_ADDR_W; FSM states IDLE, ADDR_HI (SPLIT only), SETUP, STROBE, DONE.
REQ-022 IDLE: cpu_req=1 SHALL latch cpu_we/cpu_addr/cpu_wdata and go to ADDR_HI (SPLIT) else SETUP; cpu_req=0 stays IDLE.
REQ-023 ADDR_HI (1 cycle): pin_addr = cpu_addr[ADDR_W-1:PIN_ADDR_W] zero-extended, pin_ale=1; next SETUP.
REQ-024 SETUP (1 cycle): pin_addr = cpu_addr[PIN_ADDR_W-1:0]; read: pin_oe=1; write: pin_data_oe=1, pin_data_out=latched wdata, pin_we=0; next STROBE.
REQ-025 STROBE lasts WAIT_CYCLES+1 cycles (internal counter); write: pin_we=1; read: pin_oe=1; low address held.
REQ-026 Read: pin_data_in SHALL be captured into cpu_rdata at the end of the final STROBE cycle.
REQ-027 DONE (1 cycle): pin_we=0, pin_oe=0; write keeps pin_data_oe=1 and data/address held (hold time); cpu_ready=1; next IDLE.
REQ-028 Latency, accept cycle = 0: cpu_ready in cycle WAIT_CYCLES+4 (SPLIT) or WAIT_CYCLES+3 (non-SPLIT).
REQ-029 cpu_req outside IDLE SHALL be ignored; a continuously held cpu_req yields back-to-back transactions separated by exactly one IDLE cycle.
REQ-030 pin_oe and pin_data_oe SHALL never be 1 in the same cycle; pin_we=1 only when pin_data_oe=1.
REQ-031 Outside active phases pin_ale, pin_we, pin_oe, pin_data_oe SHALL be 0; pin_addr and pin_data_out hold last value.
REQ-032 Non-SPLIT: pin_ale SHALL stay 0 permanently.
REQ-033 Writes SHALL leave cpu_rdata unchanged.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE, pin_addr=0, pin_data_out=0, cpu_rdata=0, all strobes/enables/cpu_ready/cpu_busy=0 from the next cycle, in any state.
REQ-035 A transaction interrupted by reset SHALL be discarded: no cpu_ready, no cpu_rdata update.
REQ-036 cpu_req asserted while reset=1 SHALL be ignored.

Verification (ADDR_W=8, PIN_ADDR_W=5, WAIT_CYCLES=1 unless stated)
REQ-037 Read 0xBA, pin_data_in=0x5C -> cycle1 pin_addr=0x05 pin_ale=1; cycles2-4 pin_addr=0x1A pin_oe=1; cycle5 cpu_ready=1, cpu_rdata=0x5C.
REQ-038 Write 0x3F to 0xE7 -> cycle1 pin_addr=0x07 ale=1; pin_addr=0x07 cycles2-5; pin_data_oe=1 cycles2-5; pin_we=1 cycles3-4; pin_data_out=0x3F; cpu_ready cycle5.
REQ-039 ADDR_W=5 read 0x11, WAIT_CYCLES=0 -> pin_ale never 1, pin_oe cycles1-2, cpu_ready cycle3; WAIT_CYCLES=3 -> cpu_ready cycle6.
REQ-040 Reset during second STROBE cycle of a write -> next cycle pin_we=0, pin_data_oe=0, cpu_busy=0, no cpu_ready ever for that transaction.
REQ-041 cpu_req held high over two reads (0x20, then 0x40) -> second accepted in IDLE cycle after first cpu_ready; cpu_req pulses during busy produce no extra transaction.
REQ-042 Assertion checker over all scenarios: REQ-030 invariants and cpu_ready width exactly one cycle.
